// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write-back port and an
// integrated busy-bit scoreboard for decode/write-back hazard detection.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_back_en,
  input  logic [ADDR_W-1:0] write_back_reg,
  input  logic [DATA_W-1:0] write_back,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [ADDR_W-1:0] b_reg,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              a_busy,
  output logic              b_busy,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              issue_ok,
  output logic [ADDR_W:0]   busy_count,
  output logic              waw_err
);

  // Storage spans the full index space; entries outside NUM_REGS are never
  // written and stay zero, so any index can be looked up without a range check.
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic a_ok, b_ok, wb_ok, issue_valid;
  logic a_fwd, b_fwd;
  logic issue_hit, set, inc, dec;

  function automatic logic valid_idx(input logic [ADDR_W-1:0] idx);
    valid_idx = ({1'b0, idx} < (ADDR_W+1)'(NUM_REGS)) &&
                !((ZERO_REG != 0) && (idx == '0));
  endfunction

  always_comb begin
    a_ok        = valid_idx(a_reg);
    b_ok        = valid_idx(b_reg);
    wb_ok       = write_back_en && valid_idx(write_back_reg);
    issue_valid = valid_idx(issue_reg);
    a_fwd       = (BYPASS != 0) && wb_ok && (write_back_reg == a_reg);
    b_fwd       = (BYPASS != 0) && wb_ok && (write_back_reg == b_reg);
  end

  always_comb begin
    a      = '0;
    b      = '0;
    a_busy = 1'b0;
    b_busy = 1'b0;
    if (a_ok) begin
      a      = a_fwd ? write_back : regs[a_reg];
      a_busy = busy[a_reg] && !a_fwd;
    end
    if (b_ok) begin
      b      = b_fwd ? write_back : regs[b_reg];
      b_busy = busy[b_reg] && !b_fwd;
    end
  end

  // A register being cleared this cycle may be re-issued on the same edge.
  always_comb begin
    issue_hit = write_back_en && (write_back_reg == issue_reg);
    issue_ok  = !busy[issue_reg] || issue_hit;
    set       = issue_en && issue_ok && issue_valid;
    inc       = set && !busy[issue_reg];
    dec       = wb_ok && busy[write_back_reg] &&
                !(set && (issue_reg == write_back_reg));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wb_ok) begin
      regs[write_back_reg] <= write_back;
    end
  end

  // Set is applied after clear so that a same-index set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_ok) busy[write_back_reg] <= 1'b0;
      if (set)   busy[issue_reg]      <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_count <= '0;
    end else if (inc && !dec) begin
      busy_count <= busy_count + (ADDR_W+1)'(1);
    end else if (dec && !inc) begin
      busy_count <= busy_count - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waw_err <= 1'b0;
    end else if (issue_en && !issue_ok) begin
      waw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a directed vector table for the main
// register/scoreboard flow plus hand sequences for reset, bypass and range.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_back_en;
  logic [4:0]  write_back_reg;
  logic [31:0] write_back;
  logic [4:0]  a_reg, b_reg;
  logic        issue_en;
  logic [4:0]  issue_reg;

  logic [31:0] a, b;
  logic        a_busy, b_busy, issue_ok, waw_err;
  logic [5:0]  busy_count;

  logic [31:0] nb_a, nb_b;
  logic        nb_a_busy, nb_b_busy, nb_issue_ok, nb_waw_err;
  logic [5:0]  nb_busy_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .write_back_en(write_back_en), .write_back_reg(write_back_reg),
    .write_back(write_back), .a_reg(a_reg), .b_reg(b_reg),
    .a(a), .b(b), .a_busy(a_busy), .b_busy(b_busy),
    .issue_en(issue_en), .issue_reg(issue_reg), .issue_ok(issue_ok),
    .busy_count(busy_count), .waw_err(waw_err)
  );

  // Second instance: no bypass and only 24 registers, for the range checks.
  regfile_sb #(.NUM_REGS(24), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .write_back_en(write_back_en), .write_back_reg(write_back_reg),
    .write_back(write_back), .a_reg(a_reg), .b_reg(b_reg),
    .a(nb_a), .b(nb_b), .a_busy(nb_a_busy), .b_busy(nb_b_busy),
    .issue_en(issue_en), .issue_reg(issue_reg), .issue_ok(nb_issue_ok),
    .busy_count(nb_busy_count), .waw_err(nb_waw_err)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  ar;
    logic [4:0]  br;
    logic        ien;
    logic [4:0]  ireg;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eab;
    logic        ebb;
    logic        eok;
    logic [5:0]  ecnt;
    logic        ewaw;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic wen, input logic [4:0] wreg,
                               input logic [31:0] wdata, input logic [4:0] ar,
                               input logic [4:0] br, input logic ien,
                               input logic [4:0] ireg);
    write_back_en  = wen;
    write_back_reg = wreg;
    write_back     = wdata;
    a_reg          = ar;
    b_reg          = br;
    issue_en       = ien;
    issue_reg      = ireg;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // Outputs listed are the values expected before the edge that applies the row.
    //                wen wreg wdata         ar  br  ien ireg  ea            eb  eab ebb eok cnt waw
    vecs.push_back('{0, 0, 32'h0,          5, 0, 0, 0,  32'h0,        32'h0, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 5, 32'hDEADBEEF,   5, 6, 0, 0,  32'hDEADBEEF, 32'h0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 32'h0,          5, 6, 0, 0,  32'hDEADBEEF, 32'h0, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h12345678,   0, 0, 1, 0,  32'h0,        32'h0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 32'h0,          0, 0, 0, 0,  32'h0,        32'h0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 32'h0,          3, 0, 1, 3,  32'h0,        32'h0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 32'h0,          3, 4, 1, 4,  32'h0,        32'h0, 1, 0, 1, 1, 0});
    vecs.push_back('{1, 3, 32'h11,         3, 4, 0, 0,  32'h11,       32'h0, 0, 1, 1, 2, 0});
    vecs.push_back('{0, 0, 32'h0,          3, 4, 0, 0,  32'h11,       32'h0, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 0, 32'h0,          9, 4, 1, 9,  32'h0,        32'h0, 0, 1, 1, 1, 0});
    vecs.push_back('{1, 9, 32'h99,         9, 4, 1, 9,  32'h99,       32'h0, 0, 1, 1, 2, 0});
    vecs.push_back('{0, 0, 32'h0,          9, 4, 0, 9,  32'h99,       32'h0, 1, 1, 0, 2, 0});
    vecs.push_back('{0, 0, 32'h0,          2, 9, 1, 2,  32'h0,        32'h99, 0, 1, 1, 2, 0});
    vecs.push_back('{0, 0, 32'h0,          2, 9, 1, 2,  32'h0,        32'h99, 1, 1, 0, 3, 0});
    vecs.push_back('{0, 0, 32'h0,          2, 9, 0, 2,  32'h0,        32'h99, 1, 1, 0, 3, 1});
    vecs.push_back('{1, 2, 32'h22,         2, 9, 0, 2,  32'h22,       32'h99, 0, 1, 1, 3, 1});
    vecs.push_back('{0, 0, 32'h0,          2, 9, 0, 2,  32'h22,       32'h99, 0, 1, 1, 2, 1});

    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);
    #12 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].wen, vecs[i].wreg, vecs[i].wdata, vecs[i].ar,
                    vecs[i].br, vecs[i].ien, vecs[i].ireg);
      #2;
      checkOutput($sformatf("v%0d a", i), a, vecs[i].ea);
      checkOutput($sformatf("v%0d b", i), b, vecs[i].eb);
      checkOutput($sformatf("v%0d a_busy", i), 32'(a_busy), 32'(vecs[i].eab));
      checkOutput($sformatf("v%0d b_busy", i), 32'(b_busy), 32'(vecs[i].ebb));
      checkOutput($sformatf("v%0d issue_ok", i), 32'(issue_ok), 32'(vecs[i].eok));
      checkOutput($sformatf("v%0d busy_count", i), 32'(busy_count), 32'(vecs[i].ecnt));
      checkOutput($sformatf("v%0d waw_err", i), 32'(waw_err), 32'(vecs[i].ewaw));
    end

    // Asynchronous reset between edges: state must clear without a clock edge.
    @(negedge clk);
    applyStimulus(0, 0, 32'h0, 5, 4, 0, 9);
    #1;
    checkOutput("pre_rst a", a, 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst a", a, 32'h0);
    checkOutput("rst b_busy", 32'(b_busy), 32'h0);
    checkOutput("rst busy_count", 32'(busy_count), 32'h0);
    checkOutput("rst waw_err", 32'(waw_err), 32'h0);
    checkOutput("rst issue_ok", 32'(issue_ok), 32'h1);
    #1 rst = 1'b0;

    // Same-cycle forwarding versus registered visibility.
    @(negedge clk);
    applyStimulus(1, 7, 32'hCAFEF00D, 7, 7, 0, 0);
    #2;
    checkOutput("byp a", a, 32'hCAFEF00D);
    checkOutput("byp b", b, 32'hCAFEF00D);
    checkOutput("nobyp a old", nb_a, 32'h0);
    checkOutput("nobyp b old", nb_b, 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 32'h0, 7, 7, 0, 0);
    #2;
    checkOutput("nobyp a new", nb_a, 32'hCAFEF00D);
    checkOutput("nobyp b new", nb_b, 32'hCAFEF00D);

    // Index 30 is beyond 24 registers in dut_nb but valid in dut.
    @(negedge clk);
    applyStimulus(1, 30, 32'h55, 30, 0, 1, 30);
    #2;
    checkOutput("oor nb a", nb_a, 32'h0);
    checkOutput("oor nb issue_ok", 32'(nb_issue_ok), 32'h1);
    @(negedge clk);
    applyStimulus(0, 0, 32'h0, 30, 0, 0, 30);
    #2;
    checkOutput("oor nb a after", nb_a, 32'h0);
    checkOutput("oor nb a_busy", 32'(nb_a_busy), 32'h0);
    checkOutput("oor nb busy_count", 32'(nb_busy_count), 32'h0);
    checkOutput("oor nb issue_ok after", 32'(nb_issue_ok), 32'h1);
    checkOutput("in range a", a, 32'h55);
    checkOutput("in range a_busy", 32'(a_busy), 32'h1);
    checkOutput("in range busy_count", 32'(busy_count), 32'h1);
    checkOutput("in range issue_ok", 32'(issue_ok), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised next-generation CPU register file: two combinational read ports, one write-back port, optional hardwired zero register, optional write-to-read bypass. Adds an integrated scoreboard: issue marks a destination register busy, write-back clears it. Read-port busy flags, an issue-ready check, a busy-register count and a sticky WAW error flag feed the pipeline hazard/stall logic between decode and write-back.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register index width
NUM_REGS, 32, number of registers; must be at most 2**ADDR_W
ZERO_REG, 1, 1: register 0 reads 0, ignores writes, and is never marked busy
BYPASS, 1, 1: same-cycle write-back forwarded to read ports and busy flags

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
write_back_en  in  1  write-back strobe
write_back_reg  in  ADDR_W  write-back destination index
write_back  in  DATA_W  write-back data
a_reg  in  ADDR_W  read port A index
b_reg  in  ADDR_W  read port B index
a  out  DATA_W  read port A data
b  out  DATA_W  read port B data
a_busy  out  1  register a_reg has an outstanding producer
b_busy  out  1  register b_reg has an outstanding producer
issue_en  in  1  issue strobe: mark issue_reg busy
issue_reg  in  ADDR_W  destination index of issuing instruction
issue_ok  out  1  issue_reg is free or being cleared this cycle
busy_count  out  ADDR_W+1  number of registers currently busy
waw_err  out  1  sticky: issue attempted while issue_ok low

Behaviour:
- Reset (async, immediate, mid-operation included): all registers 0, all busy bits 0, busy_count 0, waw_err 0. After reset, a = b = 0, a_busy = b_busy = 0, issue_ok = 1.
- Index >= NUM_REGS: reads return 0 with busy 0; writes and issues ignored.
- Reads are combinational from stored state, zero latency.
- ZERO_REG=1: index 0 always reads 0, busy 0; write_back_en to 0 is a no-op; issue to 0 is a no-op and is always issue_ok=1.
- Write: on rising clk with write_back_en, registers[write_back_reg] <= write_back; visible on reads the following cycle (BYPASS=0).
- BYPASS=1: if write_back_en and write_back_reg == a_reg (valid, non-zero when ZERO_REG), a = write_back and a_busy = 0 in the same cycle; same for b.
- Scoreboard, per rising edge:
  - clear: write_back_en clears busy[write_back_reg]; write-back to a non-busy register is legal (plain write).
  - set: issue_en with issue_ok=1 sets busy[issue_reg].
  - same index set and clear: set wins, busy stays 1.
- issue_ok = !busy[issue_reg] || (write_back_en && write_back_reg == issue_reg); combinational, independent of BYPASS.
- issue_en with issue_ok=0: issue ignored (busy unchanged), waw_err set to 1 next edge; waw_err clears only on rst.
- busy_count: updated every edge: +1 for an accepted set of a non-busy register, -1 for a clear of a busy register not simultaneously re-set, net 0 otherwise. Always equals the popcount of the busy bits; max NUM_REGS (minus 1 when ZERO_REG), no wrap.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst between edges -> a (a_reg=5) = 0 immediately, busy_count = 0, waw_err = 0.
- Zero reg: write 0x12345678 to r0, issue r0 -> a = 0, a_busy = 0, busy_count = 0, issue_ok = 1.
- Bypass: write 0xCAFEF00D to r7 with a_reg=b_reg=7 -> BYPASS=1: a = b = 0xCAFEF00D the same cycle; BYPASS=0: old value, new value next cycle.
- Scoreboard: issue r3, then r4 -> busy_count = 2, a_busy=1 for a_reg=3; write-back r3 with 0x11 -> busy_count = 1, a = 0x11, a_busy = 0.
- Simultaneous: r9 busy, write-back r9 with issue r9 same edge -> issue_ok = 1, r9 stays busy, busy_count unchanged, waw_err = 0.
- WAW: r2 busy, issue r2 without write-back -> issue_ok = 0, busy_count unchanged, waw_err = 1 and stays 1 until rst.
